// File: rtl/trdb_branch_map.sv
// trdb_branch_map: accumulates conditional-branch outcomes into a bit map for
// the trace packet emitter.
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   valid_i, is_branch_i     retire strobe and conditional-branch qualifier
//   is_branch_taken_i        branch outcome (stored as 1 = not taken, 0 = taken)
//   flush_i                  emitter consumed the map; clear it
//   map_o, branches_o        registered map contents and entry count
//   full_o, empty_o          count == NBRANCHES / count == 0 (from registered count)
//   overflow_o               one-cycle pulse when a branch is dropped while full
module trdb_branch_map #(
  parameter int unsigned NBRANCHES = 31,
  parameter int unsigned CNTLEN    = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic                 is_branch_i,
  input  logic                 is_branch_taken_i,
  input  logic                 flush_i,
  output logic [NBRANCHES-1:0] map_o,
  output logic [CNTLEN-1:0]    branches_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 overflow_o
);

  localparam logic [CNTLEN-1:0] FullCnt = CNTLEN'(NBRANCHES);

  logic [NBRANCHES-1:0] map_q, map_d;
  logic [CNTLEN-1:0]    cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic branch_ev;
  logic nt_bit;
  logic full;

  assign branch_ev = valid_i & is_branch_i;
  assign nt_bit    = ~is_branch_taken_i;
  assign full      = (cnt_q == FullCnt);

  // Next-state: flush wins over append, but a branch arriving with the flush
  // becomes entry 0 of the fresh map so it is never lost.
  always_comb begin
    map_d = map_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (flush_i) begin
      map_d = '0;
      cnt_d = '0;
      if (branch_ev) begin
        map_d[0] = nt_bit;
        cnt_d    = CNTLEN'(1);
      end
    end else if (branch_ev) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < NBRANCHES; i++) begin
          if (cnt_q == CNTLEN'(i)) map_d[i] = nt_bit;
        end
        cnt_d = cnt_q + CNTLEN'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      map_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      map_q <= map_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign map_o      = map_q;
  assign branches_o = cnt_q;
  assign overflow_o = ovf_q;
  assign full_o     = full;
  assign empty_o    = (cnt_q == '0);

endmodule

// File: tb/tb_trdb_branch_map.sv
// Directed bench for trdb_branch_map: hand-computed expectations for append,
// encoding, flush (with and without a concurrent branch), overflow and reset.
module tb_trdb_branch_map;

  localparam int unsigned NB = 31;
  localparam int unsigned CL = 5;

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic          is_br;
  logic          taken;
  logic          flush;
  logic [NB-1:0] map;
  logic [CL-1:0] branches;
  logic          full;
  logic          empty;
  logic          overflow;

  int n_cmp;
  int n_err;

  trdb_branch_map #(.NBRANCHES(NB), .CNTLEN(CL)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .valid_i           (valid),
    .is_branch_i       (is_br),
    .is_branch_taken_i (taken),
    .flush_i           (flush),
    .map_o             (map),
    .branches_o        (branches),
    .full_o            (full),
    .empty_o           (empty),
    .overflow_o        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic t, input logic f);
    valid = v;
    is_br = b;
    taken = t;
    flush = f;
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] emap,
                             input logic [31:0] ecnt, input logic eovf);
    check({tag, ".map"}, 32'(map), emap);
    check({tag, ".cnt"}, 32'(branches), ecnt);
    check({tag, ".full"}, 32'(full), 32'(ecnt == NB));
    check({tag, ".empty"}, 32'(empty), 32'(ecnt == 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(eovf));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    check_state("reset", 32'h0, 0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_state("post_reset_idle", 32'h0, 0, 1'b0);

    // taken, not-taken, not-taken -> map[2:0] = 3'b110
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    check_state("seq1", 32'h0, 1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_state("seq2", 32'h2, 2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_state("seq3", 32'h6, 3, 1'b0);

    // Non-branch retirements and idle branch flag leave state alone.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'(i % 2), 1'b0);
      step();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check_state("nonbranch", 32'h6, 3, 1'b0);

    // Clear, then build count 7 with pattern nt,t,nt,t,t,nt,nt -> 0x65.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check_state("flush_to_0", 32'h0, 0, 1'b0);
    begin
      logic [6:0] tk;
      tk = 7'b0011010;
      for (int i = 0; i < 7; i++) begin
        drive(1'b1, 1'b1, tk[i], 1'b0);
        step();
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("cnt7", 32'h65, 7, 1'b0);

    // Flush with no branch: held during the flush cycle, cleared after.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check_state("flush7_hold", 32'h65, 7, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("flush7_after", 32'h0, 0, 1'b0);

    // Flush while empty is a no-op.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("flush_empty", 32'h0, 0, 1'b0);

    // Count 5 (all not-taken), then flush + taken branch together.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check_state("flush5_hold", 32'h1F, 5, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("flush5_taken", 32'h0, 1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_state("after_flush_append", 32'h2, 2, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("flush_nt", 32'h1, 1, 1'b0);

    // Fill to capacity with not-taken branches.
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("full", 32'h7FFF_FFFF, 31, 1'b0);
    // 32nd branch is dropped and reported for exactly one cycle.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("overflow", 32'h7FFF_FFFF, 31, 1'b1);
    step();
    check_state("overflow_end", 32'h7FFF_FFFF, 31, 1'b0);
    // Flush with a branch while full restarts at index 0.
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("flush_full", 32'h1, 1, 1'b0);

    // Build count 12 (11 more taken), then async reset mid-cycle.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("cnt12", 32'h1, 12, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_reset", 32'h0, 0, 1'b0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_state("restart", 32'h1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trdb_branch_map.md
TRDB_BRANCH_MAP -- requirements
Module: trdb_branch_map

Interface
REQ-001 SHALL have parameter NBRANCHES, default 31, the branch map capacity in entries.
REQ-002 SHALL have parameter CNTLEN, default 5, the branch count width; it SHALL satisfy 2^CNTLEN > NBRANCHES.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port valid_i, input, 1 bit: an instruction retired this cycle.
REQ-006 SHALL have port is_branch_i, input, 1 bit: the retired instruction is a conditional branch.
REQ-007 SHALL have port is_branch_taken_i, input, 1 bit: the branch was taken; it is ignored unless valid_i && is_branch_i.
REQ-008 SHALL have port flush_i, input, 1 bit: flush request from the packet emitter (its branch_map_flush output).
REQ-009 SHALL have port map_o, output, NBRANCHES bits: the registered branch map; bit i holds the i-th recorded branch.
REQ-010 SHALL have port branches_o, output, CNTLEN bits: the registered count of valid map entries.
REQ-011 SHALL have port full_o, output, 1 bit: branches_o == NBRANCHES.
REQ-012 SHALL have port empty_o, output, 1 bit: branches_o == 0.
REQ-013 SHALL have port overflow_o, output, 1 bit: one-cycle pulse reporting that a branch was dropped.

Function
REQ-014 SHALL define a branch event as valid_i && is_branch_i in the same cycle.
REQ-015 SHALL encode each map bit per the E-trace convention: 1 = not taken, 0 = taken.
REQ-016 SHALL, on a branch event with flush_i=0 and not full, write the encoded bit to map index branches_o and increment the count; visible on the next cycle (latency 1).
REQ-017 SHALL leave map and count unchanged on cycles with no branch event and flush_i=0.
REQ-018 SHALL, on flush_i=1 with no branch event, clear the map to 0 and the count to 0 on the next cycle.
REQ-019 SHALL, on flush_i=1 with a branch event in the same cycle, store the new bit at index 0 (all other bits cleared) and set the count to 1; the new branch SHALL NOT be lost.
REQ-020 SHALL hold map_o and branches_o at their pre-flush values during the cycle flush_i is asserted, so the emitter samples the map in the same cycle it flushes.
REQ-021 SHALL, on a branch event while full_o=1 and flush_i=0, discard the branch, keep map and count unchanged, and pulse overflow_o=1 for exactly one cycle (registered, next cycle).
REQ-022 SHALL never let the count exceed NBRANCHES (no wrap-around).
REQ-023 SHALL keep map bits at index >= branches_o at 0.
REQ-024 SHALL derive full_o and empty_o combinationally from the registered count (no extra latency).
REQ-025 SHALL treat flush_i while empty as a legal no-op.

Reset
REQ-026 SHALL, on rst_ni=0 (asynchronous, any cycle, including mid-accumulation), force map_o=0, branches_o=0, overflow_o=0, full_o=0 and empty_o=1 immediately.
REQ-027 SHALL resume normal recording on the first rising edge after rst_ni deasserts.

Verification
REQ-028 Reset then branches taken, not-taken, not-taken on 3 consecutive cycles -> branches_o=3, map_o[2:0]=3'b110, empty_o=0.
REQ-029 31 branches (all not-taken) -> full_o=1, map_o=all 1s; a 32nd branch without flush -> overflow_o=1 for one cycle, map and count unchanged.
REQ-030 Count=5 with flush_i=1 and a taken branch in the same cycle -> map_o and branches_o=5 held that cycle; next cycle branches_o=1, map_o=0.
REQ-031 Count=7 with flush_i=1 and no branch -> next cycle branches_o=0, map_o=0, empty_o=1.
REQ-032 valid_i=1 with is_branch_i=0 and is_branch_taken_i toggling -> no change to map_o or branches_o.
REQ-033 rst_ni asserted asynchronously between clock edges at count=12 -> outputs reach their reset values before the next edge; recording restarts at index 0.
